// File: rtl/inst_fetch_mem.sv
// Instruction memory: a program store that the bench loads, plus a valid/ready fetch port
// with a registered one-cycle read. Faulting fetches return NOP together with a fault code.
module inst_fetch_mem #(
  parameter int unsigned       DEPTH  = 16,
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       ADDR_W = 32,
  parameter logic [DATA_W-1:0] NOP    = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  input  logic              load_start,
  output logic [15:0]       load_count,
  output logic              running,
  input  logic              fetch_req_valid,
  output logic              fetch_req_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_resp_valid,
  input  logic              fetch_resp_ready,
  output logic [DATA_W-1:0] fetch_inst,
  output logic [1:0]        fetch_fault
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WIDX_W = ADDR_W - 2;
  localparam logic [1:0]  FLT_OK    = 2'b00;
  localparam logic [1:0]  FLT_RANGE = 2'b01;
  localparam logic [1:0]  FLT_ALIGN = 2'b10;

  typedef enum logic [0:0] {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
  logic [15:0]         r_load_count;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_inst;
  logic [1:0]          r_fault;

  logic [WIDX_W-1:0]   w_load_idx;
  logic [WIDX_W-1:0]   w_fetch_idx;
  logic                w_load_ok;
  logic                w_fetch_mis;
  logic                w_fetch_oor;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [DATA_W-1:0]   w_rd_word;
  logic                w_load_wr;
  logic                w_ready;
  logic                w_accept;
  logic                w_start;

  // Address decode: word index plus range and alignment qualification
  assign w_load_idx  = load_addr[ADDR_W-1:2];
  assign w_fetch_idx = fetch_addr[ADDR_W-1:2];
  assign w_load_ok   = (load_addr[1:0] == 2'b00) && (w_load_idx < WIDX_W'(DEPTH));
  assign w_fetch_mis = (fetch_addr[1:0] != 2'b00);
  assign w_fetch_oor = !(w_fetch_idx < WIDX_W'(DEPTH));
  // Out-of-range indices are steered to word 0 so the array is never addressed past DEPTH
  assign w_rd_idx    = w_fetch_oor ? '0 : w_fetch_idx[IDX_W-1:0];
  assign w_rd_word   = r_mem[w_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  // Mode transitions plus the per-mode write/accept qualifiers
  always_comb begin
    w_state_nxt = r_state;
    w_load_wr   = 1'b0;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_load_wr = load_we && w_load_ok;
        if (load_done) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_ready  = (!r_resp_valid || fetch_resp_ready) && !load_start;
        w_accept = fetch_req_valid && w_ready;
        if (load_start) begin
          w_start     = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_load_wr) r_mem[w_load_idx[IDX_W-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          r_load_count <= '0;
    else if (w_start)                                    r_load_count <= '0;
    else if (w_load_wr && (r_load_count != 16'hFFFF))    r_load_count <= r_load_count + 16'd1;
  end

  // Response register: misalignment outranks range error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_inst       <= NOP;
      r_fault      <= FLT_OK;
    end else if (w_start) begin
      r_resp_valid <= 1'b0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      if (w_fetch_mis) begin
        r_inst  <= NOP;
        r_fault <= FLT_ALIGN;
      end else if (w_fetch_oor) begin
        r_inst  <= NOP;
        r_fault <= FLT_RANGE;
      end else begin
        r_inst  <= w_rd_word;
        r_fault <= FLT_OK;
      end
    end else if (fetch_resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign load_count       = r_load_count;
  assign running          = (r_state == S_RUN);
  assign fetch_req_ready  = w_ready;
  assign fetch_resp_valid = r_resp_valid;
  assign fetch_inst       = r_inst;
  assign fetch_fault      = r_fault;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Bench for inst_fetch_mem: a DEPTH=16 and a DEPTH=5 instance share one stimulus stream and
// are compared against an array-based program model and a queue of outstanding responses.
module tb_inst_fetch_mem;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_we, load_done, load_start;
  logic [31:0] load_addr, load_data;
  logic        frv, frr;
  logic [31:0] fetch_addr;

  logic [15:0] lc, lc5;
  logic        running, running5, req_ready, req_ready5, resp_valid, resp_valid5;
  logic [31:0] inst, inst5;
  logic [1:0]  fault, fault5;

  logic [31:0] mdl_mem [16];
  logic        m_running;
  int          m_count;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  inst_fetch_mem #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_done(load_done), .load_start(load_start), .load_count(lc), .running(running),
    .fetch_req_valid(frv), .fetch_req_ready(req_ready), .fetch_addr(fetch_addr),
    .fetch_resp_valid(resp_valid), .fetch_resp_ready(frr), .fetch_inst(inst), .fetch_fault(fault));

  inst_fetch_mem #(.DEPTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_done(load_done), .load_start(load_start), .load_count(lc5), .running(running5),
    .fetch_req_valid(frv), .fetch_req_ready(req_ready5), .fetch_addr(fetch_addr),
    .fetch_resp_valid(resp_valid5), .fetch_resp_ready(frr), .fetch_inst(inst5), .fetch_fault(fault5));

  // Expected {fault, inst} for a fetch of byte address a from a memory of the given depth
  function automatic logic [33:0] exp_resp(input logic [31:0] a, input int depth);
    if (a[1:0] != 2'b00)          return {2'b10, NOP};
    if ((a >> 2) >= 32'(depth))   return {2'b01, NOP};
    return {2'b00, mdl_mem[a >> 2]};
  endfunction

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(posedge clk);
    #1 load_we = 1'b0;
    if (!m_running && a[1:0] == 2'b00 && (a >> 2) < 32'd16) begin
      mdl_mem[a >> 2] = d;
      m_count++;
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    load_done = 1'b1;
    @(posedge clk);
    #1 load_done = 1'b0;
    m_running = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
    if (m_running) begin m_running = 1'b0; m_count = 0; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_we = 0; load_done = 0; load_start = 0; frv = 0; frr = 0;
    load_addr = '0; load_data = '0; fetch_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; m_running = 1'b0; m_count = 0;
    frv = 1'b1;
    #1;
    n_total++; if (running !== 1'b0) $display("FAIL reset_running got %0b want 0", running); else n_pass++;
    n_total++; if (lc !== 16'd0) $display("FAIL reset_count got %0d want 0", lc); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %0b want 0", resp_valid); else n_pass++;
    n_total++; if (inst !== NOP) $display("FAIL reset_inst got %h want %h", inst, NOP); else n_pass++;
    n_total++; if (fault !== 2'b00) $display("FAIL reset_fault got %b want 00", fault); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got %0b want 0", req_ready); else n_pass++;
    @(posedge clk);
    #1 frv = 1'b0;
  endtask

  task automatic test_burst();
    logic [33:0] e;
    for (int i = 0; i < 16; i++) load_word(32'(i * 4), 32'hA000_0000 + 32'(i));
    pulse_done();
    @(negedge clk);
    n_total++; if (running !== 1'b1) $display("FAIL burst_running got %0b want 1", running); else n_pass++;
    n_total++; if (lc !== 16'(m_count)) $display("FAIL burst_count got %0d want %0d", lc, m_count); else n_pass++;
    for (int n = 0; n <= 16; n++) begin
      if (n > 0) @(negedge clk);
      frv = (n < 16); fetch_addr = 32'(n * 4); frr = 1'b1;
      #1;
      n_total++; if (req_ready !== 1'b1) $display("FAIL burst_ready[%0d] got %0b want 1", n, req_ready); else n_pass++;
      if (n > 0) begin
        e = exp_resp(32'((n - 1) * 4), 16);
        n_total++; if (resp_valid !== 1'b1) $display("FAIL burst_valid[%0d] got %0b want 1", n, resp_valid); else n_pass++;
        n_total++; if ({fault, inst} !== e) $display("FAIL burst_data[%0d] got %b/%h want %b/%h", n, fault, inst, e[33:32], e[31:0]); else n_pass++;
      end
    end
    @(negedge clk);
    frv = 1'b0;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL burst_drain got %0b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_faults();
    logic [31:0] addrs [3];
    logic [33:0] e;
    addrs[0] = 32'h0000_0040; addrs[1] = 32'h0000_0006; addrs[2] = 32'hFFFF_FFFD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      frv = 1'b1; fetch_addr = addrs[k]; frr = 1'b1;
      @(posedge clk);
      #1 frv = 1'b0;
      @(negedge clk);
      e = exp_resp(addrs[k], 16);
      n_total++; if (resp_valid !== 1'b1) $display("FAIL fault_valid[%h] got %0b want 1", addrs[k], resp_valid); else n_pass++;
      n_total++; if ({fault, inst} !== e) $display("FAIL fault_data[%h] got %b/%h want %b/%h", addrs[k], fault, inst, e[33:32], e[31:0]); else n_pass++;
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    frv = 1'b1; fetch_addr = 32'h8; frr = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      frv = 1'b1; fetch_addr = 32'hC; frr = 1'b0;
      #1;
      n_total++; if (resp_valid !== 1'b1) $display("FAIL hold_valid[%0d] got %0b want 1", k, resp_valid); else n_pass++;
      n_total++; if ({fault, inst} !== {2'b00, mdl_mem[2]}) $display("FAIL hold_data[%0d] got %b/%h want 00/%h", k, fault, inst, mdl_mem[2]); else n_pass++;
      n_total++; if (req_ready !== 1'b0) $display("FAIL hold_ready[%0d] got %0b want 0", k, req_ready); else n_pass++;
    end
    @(negedge clk);
    frr = 1'b1;
    #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL hold_release_ready got %0b want 1", req_ready); else n_pass++;
    @(posedge clk);
    #1 frv = 1'b0;
    @(negedge clk);
    n_total++; if ({resp_valid, fault, inst} !== {1'b1, 2'b00, mdl_mem[3]}) $display("FAIL hold_next got %0b/%b/%h want 1/00/%h", resp_valid, fault, inst, mdl_mem[3]); else n_pass++;
  endtask

  task automatic test_load_guards();
    pulse_start();
    @(negedge clk);
    frv = 1'b1; fetch_addr = 32'h0;
    #1;
    n_total++; if ({running, req_ready} !== 2'b00) $display("FAIL guard_load_ready got %b want 00", {running, req_ready}); else n_pass++;
    frv = 1'b0;
    load_word(32'h44, 32'h5555_5555);
    load_word(32'h2, 32'h6666_6666);
    @(negedge clk);
    n_total++; if (lc !== 16'(m_count)) $display("FAIL guard_bad_writes got %0d want %0d", lc, m_count); else n_pass++;
    load_word(32'h0, 32'h1111_0000);
    pulse_done();
    load_word(32'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    frv = 1'b1; fetch_addr = 32'h0; frr = 1'b1;
    @(posedge clk);
    #1 frv = 1'b0;
    @(negedge clk);
    n_total++; if ({resp_valid, inst} !== {1'b1, mdl_mem[0]}) $display("FAIL guard_run_write got %0b/%h want 1/%h", resp_valid, inst, mdl_mem[0]); else n_pass++;
    n_total++; if (lc !== 16'(m_count)) $display("FAIL guard_count got %0d want %0d", lc, m_count); else n_pass++;
  endtask

  task automatic test_start_drop();
    @(negedge clk);
    frv = 1'b1; fetch_addr = 32'h4; frr = 1'b0;
    @(posedge clk);
    #1 frv = 1'b0;
    @(negedge clk);
    n_total++; if (resp_valid !== 1'b1) $display("FAIL drop_pending got %0b want 1", resp_valid); else n_pass++;
    load_start = 1'b1; frv = 1'b1; fetch_addr = 32'h8; frr = 1'b1;
    #1;
    n_total++; if (req_ready !== 1'b0) $display("FAIL drop_ready got %0b want 0", req_ready); else n_pass++;
    @(posedge clk);
    #1 load_start = 1'b0; frv = 1'b0;
    m_running = 1'b0; m_count = 0;
    @(negedge clk);
    n_total++; if ({resp_valid, running, lc} !== {1'b0, 1'b0, 16'd0}) $display("FAIL drop_state got %0b/%0b/%0d want 0/0/0", resp_valid, running, lc); else n_pass++;
    for (int i = 0; i < 4; i++) load_word(32'(i * 4), $urandom);
    pulse_done();
    @(negedge clk);
    frv = 1'b1; fetch_addr = 32'hC;
    @(posedge clk);
    #1 frv = 1'b0;
    @(negedge clk);
    n_total++; if ({resp_valid, fault, inst} !== {1'b1, 2'b00, mdl_mem[3]}) $display("FAIL drop_reload got %0b/%b/%h want 1/00/%h", resp_valid, fault, inst, mdl_mem[3]); else n_pass++;
  endtask

  task automatic test_random();
    logic [33:0] q[$];
    logic [31:0] a;
    logic        exp_ready;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      a = $urandom_range(0, 9);
      if (a < 6)       a = 32'($urandom_range(0, 15)) << 2;
      else if (a < 8)  a = 32'($urandom_range(16, 40)) << 2;
      else begin a = $urandom; a[1:0] = 2'($urandom_range(1, 3)); end
      frv = 1'($urandom_range(0, 1)); frr = ($urandom_range(0, 3) != 0); fetch_addr = a;
      #1;
      exp_ready = (q.size() == 0) || frr;
      n_total++; if (resp_valid !== (q.size() != 0)) $display("FAIL rand_valid[%0d] got %0b want %0b", c, resp_valid, q.size() != 0); else n_pass++;
      if (q.size() != 0) begin
        n_total++; if ({fault, inst} !== q[0]) $display("FAIL rand_data[%0d] got %b/%h want %b/%h", c, fault, inst, q[0][33:32], q[0][31:0]); else n_pass++;
      end
      n_total++; if (req_ready !== exp_ready) $display("FAIL rand_ready[%0d] got %0b want %0b", c, req_ready, exp_ready); else n_pass++;
      @(posedge clk);
      if (q.size() != 0 && frr) void'(q.pop_front());
      if (frv && exp_ready) q.push_back(exp_resp(a, 16));
    end
    @(negedge clk);
    frv = 1'b0; frr = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_async_reset();
    logic [31:0] addrs [2];
    logic [33:0] e;
    @(negedge clk);
    frv = 1'b1; fetch_addr = 32'h0; frr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({resp_valid, running, resp_valid5, running5} !== 4'b0000) $display("FAIL async_reset got %b want 0000", {resp_valid, running, resp_valid5, running5}); else n_pass++;
    frv = 1'b0; m_running = 1'b0; m_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) load_word(32'(i * 4), $urandom);
    pulse_done();
    @(negedge clk);
    n_total++; if ({lc, lc5} !== {16'(m_count), 16'(m_count)}) $display("FAIL depth5_count got %0d/%0d want %0d", lc, lc5, m_count); else n_pass++;
    n_total++; if ({running5, req_ready5} !== 2'b11) $display("FAIL depth5_ready got %b want 11", {running5, req_ready5}); else n_pass++;
    addrs[0] = 32'h14; addrs[1] = 32'h10;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      frv = 1'b1; fetch_addr = addrs[k];
      @(posedge clk);
      #1 frv = 1'b0;
      @(negedge clk);
      e = exp_resp(addrs[k], 5);
      n_total++; if ({resp_valid5, fault5, inst5} !== {1'b1, e}) $display("FAIL depth5_data[%h] got %0b/%b/%h want 1/%b/%h", addrs[k], resp_valid5, fault5, inst5, e[33:32], e[31:0]); else n_pass++;
      e = exp_resp(addrs[k], 16);
      n_total++; if ({resp_valid, fault, inst} !== {1'b1, e}) $display("FAIL depth16_data[%h] got %0b/%b/%h want 1/%b/%h", addrs[k], resp_valid, fault, inst, e[33:32], e[31:0]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_faults();
    test_hold();
    test_load_guards();
    test_start_drop();
    test_random();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
